ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED LED set, 0xF4 enable,
//  0xFF reset) to keyboard/mouse using the inhibit / request-to-send / device-clocked protocol.

---
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one byte to a PS/2 keyboard/mouse using the inhibit, request-to-send and
// device-clocked handshake. It shares the open-drain ps2 pins with the receive
// controller, and o_busy tells the receiver to ignore the line.
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles the ps2 clock is held low before request-to-send
//   TIMEOUT_CYCLES  max clk cycles between consecutive device clock falling edges
//   SYNC_STAGES     synchroniser depth on the raw ps2 inputs (>= 2)
//
// Ports:
//   i_clk, i_reset       system clock, synchronous active-high reset
//   i_tx_valid/o_tx_ready byte handshake; i_tx_data is sent LSB first
//   o_busy               high whenever a transfer is in progress
//   o_done               one-cycle pulse when the byte is sent and ACKed
//   o_error              one-cycle pulse on NACK or watchdog timeout
//   i_ps2_clk/i_ps2_data raw asynchronous pin levels
//   o_ps2_clk_oe/o_ps2_data_oe 1 pulls the pin low, 0 releases it
//
// Optional build macro: PS2_TX_RETRY_EN. When it is defined, a NACK or timeout
// resends the latched byte once before o_error is reported.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
    logic                   r_clk_prev;
    logic [9:0]             r_shift;
    logic [3:0]             r_edge_cnt;
    logic [IW-1:0]          r_inh_cnt;
    logic [TW-1:0]          r_wd_cnt;
    logic                   r_done, r_error;

    logic       w_clk_s, w_data_s, w_fall;
    logic       w_timed, w_ok, w_timeout, w_fail, w_retry, w_load;
    logic [7:0] w_load_byte;

`ifdef PS2_TX_RETRY_EN
    logic [7:0] r_byte;
    logic       r_retried;
`endif

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;

    // States in which the device owns the clock and the watchdog runs.
    assign w_timed   = (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_ok      = (r_state == S_WAIT_IDLE) && w_clk_s && w_data_s;
    // The counter holds cycles since the last reload, so WD_LAST here means the
    // next cycle would be the TIMEOUT_CYCLES-th without an edge.
    assign w_timeout = w_timed && !w_ok && !w_fall && (r_wd_cnt == WD_LAST);
    assign w_fail    = w_timeout || ((r_state == S_ACK) && w_fall && w_data_s);

`ifdef PS2_TX_RETRY_EN
    assign w_retry     = w_fail && !r_retried;
    assign w_load_byte = (r_state == S_IDLE) ? i_tx_data : r_byte;
`else
    assign w_retry     = 1'b0;
    assign w_load_byte = i_tx_data;
`endif

    assign w_load = ((r_state == S_IDLE) && i_tx_valid) || w_retry;

    assign o_tx_ready = (r_state == S_IDLE);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_error    = r_error;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        o_ps2_clk_oe  = 1'b0;
        o_ps2_data_oe = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_tx_valid) w_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                o_ps2_clk_oe = 1'b1;
                if (r_inh_cnt == INH_LAST) w_next = S_RTS;
            end
            S_RTS: begin
                o_ps2_clk_oe  = 1'b1;
                o_ps2_data_oe = 1'b1;
                w_next        = S_SHIFT;
            end
            S_SHIFT: begin
                // r_shift[0] is the bit currently on the line (start bit first).
                o_ps2_data_oe = ~r_shift[0];
                if (w_fall && (r_edge_cnt == 4'd9)) w_next = S_ACK;
            end
            S_ACK: begin
                if (w_fall && !w_data_s) w_next = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (w_ok) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_fail) w_next = w_retry ? S_INHIBIT : S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
            r_shift     <= '1;
            r_edge_cnt  <= '0;
            r_inh_cnt   <= '0;
            r_wd_cnt    <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            r_byte      <= '0;
            r_retried   <= 1'b0;
`endif
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev  <= w_clk_s;
            r_done      <= w_ok;
            r_error     <= w_fail && !w_retry;

            r_inh_cnt <= (r_state == S_INHIBIT) ? r_inh_cnt + 1'b1 : '0;

            if ((r_state == S_RTS) || (w_timed && w_fall)) begin
                r_wd_cnt <= TW'(1);
            end else if (w_timed) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end

            // Frame layout {parity, data, start}; ones shift in so the stop bit
            // appears after the parity bit leaves.
            if (w_load) begin
                r_shift    <= {~^w_load_byte, w_load_byte, 1'b0};
                r_edge_cnt <= '0;
            end else if ((r_state == S_SHIFT) && w_fall) begin
                r_shift    <= {1'b1, r_shift[9:1]};
                r_edge_cnt <= r_edge_cnt + 1'b1;
            end

`ifdef PS2_TX_RETRY_EN
            if ((r_state == S_IDLE) && i_tx_valid) begin
                r_byte    <= i_tx_data;
                r_retried <= 1'b0;
            end else if (w_retry) begin
                r_retried <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 300;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, error, clk_oe, data_oe;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = ~(clk_oe | dev_clk_low);
    assign ps2_data = ~(data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_reset(reset), .i_tx_valid(tx_valid), .i_tx_data(tx_data),
        .o_tx_ready(tx_ready), .o_busy(busy), .o_done(done), .o_error(error),
        .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
        .o_ps2_clk_oe(clk_oe), .o_ps2_data_oe(data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, ev_done = 0, ev_err = 0, last_rts = 0, last_err = 0, inh_run = 0;
    bit prev_rts = 1'b0;

    bit          dev_enable = 1'b1, dev_ack = 1'b0, dev_active = 1'b0;
    int          dev_half = 15, dev_frames = 0, dev_edge = 0;
    logic [10:0] dev_rx = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame on the wire, index 0 first: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction

    // Per-cycle compare of the outputs against the protocol rules.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            check("ready_vs_busy", int'(tx_ready), int'(!busy));
            check("done_and_error", int'(done && error), 0);
            if (!busy) check("idle_lines_released", int'({clk_oe, data_oe}), 0);
            if (prev_rts) check("rts_one_cycle_then_clk_released", int'({clk_oe, data_oe}), 1);
        end
        if (clk_oe && data_oe && !prev_rts) begin
            check("inhibit_len", inh_run, INH);
            last_rts = cyc;
        end
        prev_rts = clk_oe && data_oe;
        inh_run  = (clk_oe && !data_oe) ? inh_run + 1 : 0;
        if (done) ev_done++;
        if (error) begin
            ev_err++;
            last_err = cyc;
        end
    end

    task automatic run_frame();
        dev_active = 1'b1;
        dev_edge   = 0;
        repeat (dev_half) @(negedge clk);
        dev_rx[0] = ps2_data;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            dev_edge    = k;
            repeat (dev_half) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (dev_half / 2) @(negedge clk);
            dev_rx[k] = ps2_data;
            repeat (dev_half - dev_half / 2) @(negedge clk);
        end
        if (!dev_ack) dev_data_low = 1'b1;
        repeat (4) @(negedge clk);
        dev_clk_low = 1'b1;
        dev_edge    = 11;
        repeat (dev_half) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (4) @(negedge clk);
        dev_data_low = 1'b0;
        dev_frames++;
        dev_active = 1'b0;
    endtask

    // Device: answers a request-to-send (host releases clock while holding data low).
    initial begin : device
        bit prev_oe;
        prev_oe = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_oe && !clk_oe && data_oe && dev_enable) run_frame();
            prev_oe = clk_oe;
        end
    end

    task automatic wait_ready();
        for (int n = 0; n < 20000 && !tx_ready; n++) @(negedge clk);
        check("ready_before_send", int'(tx_ready), 1);
    endtask

    task automatic wait_dev_idle();
        for (int n = 0; n < 2000 && dev_active; n++) @(negedge clk);
        check("device_finished", int'(dev_active), 0);
    endtask

    task automatic send(input logic [7:0] b, input bit ack, input bit respond, input bit chk_tmo);
        int  f0, d0, e0, tries;
        bit  got, nack;
        dev_ack    = ack;
        dev_enable = respond;
        wait_ready();
        f0 = dev_frames; d0 = ev_done; e0 = ev_err;
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check("busy_after_accept", int'(busy), 1);
        got = 1'b0;
        for (int n = 0; n < 15000 && !got; n++) begin
            @(negedge clk);
            got = (ev_done != d0) || (ev_err != e0);
        end
        check("pulse_seen", int'(got), 1);
        wait_dev_idle();
        repeat (5) @(negedge clk);
        nack = respond ? ack : 1'b1;
`ifdef PS2_TX_RETRY_EN
        tries = nack ? 2 : 1;
`else
        tries = 1;
`endif
        check("done_count", ev_done - d0, nack ? 0 : 1);
        check("error_count", ev_err - e0, nack ? 1 : 0);
        check("frames_seen", dev_frames - f0, respond ? tries : 0);
        if (respond) check("frame_bits", int'(dev_rx), int'(exp_frame(b)));
        if (chk_tmo) check("timeout_latency", last_err - last_rts, TMO);
        dev_enable = 1'b1;
    endtask

    initial begin : global_watchdog
        #(10 * 150000);
        $display("FAIL global_timeout: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin : main
        int f0, d0;
        bit got;

        check("model_F4", int'(exp_frame(8'hF4)), 'h5E8);
        check("model_ED", int'(exp_frame(8'hED)), 'h7DA);

        repeat (3) @(negedge clk);
        check("reset_ready", int'(tx_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_pulses", int'({done, error}), 0);
        check("reset_lines", int'({clk_oe, data_oe}), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send(8'hF4, 1'b0, 1'b1, 1'b0);
        send(8'hED, 1'b0, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b1, 1'b0);
        send(8'h3C, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a frame, then a clean byte.
        dev_ack = 1'b0;
        wait_ready();
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int n = 0; n < 5000 && dev_edge != 5; n++) @(negedge clk);
        check("reached_edge5", dev_edge, 5);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_lines", int'({clk_oe, data_oe}), 0);
        check("midreset_ready", int'(tx_ready), 1);
        check("midreset_busy", int'(busy), 0);
        check("midreset_pulses", int'({done, error}), 0);
        wait_dev_idle();
        repeat (5) @(negedge clk);
        send(8'h55, 1'b0, 1'b1, 1'b0);

        // tx_valid held high across two bytes: second is taken only after done.
        dev_ack = 1'b0;
        wait_ready();
        f0 = dev_frames; d0 = ev_done;
        tx_valid = 1'b1;
        tx_data  = 8'h12;
        @(negedge clk);
        tx_data = 8'h34;
        got = 1'b0;
        for (int n = 0; n < 15000 && !got; n++) begin
            @(negedge clk);
            got = (ev_done != d0);
        end
        check("hold_first_done", int'(got), 1);
        check("hold_first_frames", dev_frames - f0, 1);
        check("hold_first_bits", int'(dev_rx), int'(exp_frame(8'h12)));
        @(negedge clk);
        tx_valid = 1'b0;
        check("hold_second_busy", int'(busy), 1);
        got = 1'b0;
        for (int n = 0; n < 15000 && !got; n++) begin
            @(negedge clk);
            got = (ev_done != d0 + 1);
        end
        check("hold_second_done", int'(got), 1);
        wait_dev_idle();
        check("hold_second_frames", dev_frames - f0, 2);
        check("hold_second_bits", int'(dev_rx), int'(exp_frame(8'h34)));
        repeat (5) @(negedge clk);

        // Randomised bytes, ACK/NACK mix and device clock rates.
        for (int i = 0; i < 10; i++) begin
            dev_half = int'($urandom_range(8, 20));
            send(8'($urandom), ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
